key_entry_buffer: RTL

//  Downstream consumer of the 4x4 keypad scanner. Turns its level-held key_valid/key_value into single
//  key-press events and edits a DIGITS-digit BCD entry (shift-in, backspace, clear) for live display.

---
 rtl/key_entry_buffer_pkg.sv | 22 ++
 rtl/key_entry_buffer_if.sv | 49 ++++
 rtl/key_entry_buffer_bcd_to_bin.sv | 70 +++++++
 rtl/key_entry_buffer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/key_entry_buffer_pkg.sv
// ============================================================================
// key_entry_buffer_pkg: key codes and one-hot FSM encodings for the keypad entry buffer.
// Revision 1.0
// ============================================================================
`default_nettype none

package key_entry_buffer_pkg;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
    localparam logic [3:0] KEY_BKSP      = 4'hA;
    localparam logic [3:0] KEY_CLR       = 4'hB;
    localparam logic [3:0] KEY_ENT       = 4'hE;

    typedef enum logic [2:0] {
        ST_EDIT = 3'b001,
        ST_CONV = 3'b010,
        ST_HOLD = 3'b100
    } state_e;

endpackage

`default_nettype wire

// File: rtl/key_entry_buffer_if.sv
// ============================================================================
// key_entry_buffer_if: keypad input, live entry and committed-output bundle. KEY_ENTRY_BIN_EN adds out_bin.
// Revision 1.0
// ============================================================================
`default_nettype none

interface key_entry_buffer_if #(
    parameter int DIGITS = 4
`ifdef KEY_ENTRY_BIN_EN
    , parameter int BIN_W = 14
`endif
);
    localparam int CW = $clog2(DIGITS + 1);

    logic [3:0]          key_value;
    logic                key_valid;
    logic [4*DIGITS-1:0] entry_bcd;
    logic [CW-1:0]       entry_cnt;
    logic [4*DIGITS-1:0] out_bcd;
`ifdef KEY_ENTRY_BIN_EN
    logic [BIN_W-1:0]    out_bin;
`endif
    logic                out_valid;
    logic                out_ready;
    logic                key_err;

`ifdef KEY_ENTRY_BIN_EN
    modport slave (
        input  key_value, key_valid, out_ready,
        output entry_bcd, entry_cnt, out_bcd, out_bin, out_valid, key_err
    );
    modport master (
        output key_value, key_valid, out_ready,
        input  entry_bcd, entry_cnt, out_bcd, out_bin, out_valid, key_err
    );
`else
    modport slave (
        input  key_value, key_valid, out_ready,
        output entry_bcd, entry_cnt, out_bcd, out_valid, key_err
    );
    modport master (
        output key_value, key_valid, out_ready,
        input  entry_bcd, entry_cnt, out_bcd, out_valid, key_err
    );
`endif

endinterface

`default_nettype wire

// File: rtl/key_entry_buffer_bcd_to_bin.sv
// ============================================================================
// bcd_to_bin_seq: sequential BCD-to-binary, one digit per cycle, MS digit first (bin = bin*10 + digit).
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_to_bin_seq
    import key_entry_buffer_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                start_i,
    input  wire logic [4*DIGITS-1:0] bcd_i,
    output logic                     busy_o,
    output logic [BIN_W-1:0]         bin_o
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [W-1:0]     shift_q, shift_d;
    logic [CW-1:0]    left_q, left_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             busy_q, busy_d;

    function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] acc, input logic [3:0] dig);
        return acc * BIN_W'(10) + BIN_W'(dig);
    endfunction

    // The start cycle already folds in the MS digit, so busy spans exactly DIGITS-1 cycles.
    always_comb begin
        shift_d = shift_q;
        left_d  = left_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        if (start_i) begin
            bin_d   = BIN_W'(bcd_i[W-1 -: 4]);
            shift_d = bcd_i << 4;
            left_d  = CW'(DIGITS - 1);
            busy_d  = (DIGITS > 1);
        end else if (busy_q) begin
            bin_d   = mac10(bin_q, shift_q[W-1 -: 4]);
            shift_d = shift_q << 4;
            left_d  = left_q - CW'(1);
            busy_d  = (left_q != CW'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            left_q  <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign bin_o  = bin_q;

endmodule

`default_nettype wire

// File: rtl/key_entry_buffer.sv
// ============================================================================
// key_entry_buffer: keypad presses edit a BCD entry; ENTER commits it under valid/ready.
// KEY_ENTRY_BIN_EN adds a sequential binary conversion (CONV state) and out_bin. Revision 1.0
// ============================================================================
`default_nettype none

module key_entry_buffer
    import key_entry_buffer_pkg::*;
#(
    parameter int DIGITS = 4
`ifdef KEY_ENTRY_BIN_EN
    , parameter int BIN_W = 14
`endif
) (
    input wire logic          clk,
    input wire logic          reset_n,
    key_entry_buffer_if.slave bus
);
    localparam int              W       = 4 * DIGITS;
    localparam int              CW      = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DIGITS);

    state_e          state_q, state_d;
    logic            key_valid_q;
    logic            armed_q;
    logic [W-1:0]    entry_q, entry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    out_bcd_q, out_bcd_d;
    logic            key_err_q, key_err_d;
    logic            press;
    logic            enter_ok;
`ifdef KEY_ENTRY_BIN_EN
    logic            conv_busy;
`endif

    // armed_q blocks a key already held when reset releases until it has been let go.
    assign press = bus.key_valid & ~key_valid_q & armed_q;

    always_comb begin
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        out_bcd_d = out_bcd_q;
        key_err_d = 1'b0;
        enter_ok  = 1'b0;
        if (press) begin
            if (bus.key_value <= KEY_MAX_DIGIT) begin
                if (cnt_q < CNT_MAX) begin
                    entry_d = (entry_q << 4) | W'(bus.key_value);
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    key_err_d = 1'b1;
                end
            end else begin
                case (bus.key_value)
                    KEY_BKSP: begin
                        if (cnt_q != '0) begin
                            entry_d = entry_q >> 4;
                            cnt_d   = cnt_q - CW'(1);
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                    KEY_CLR: begin
                        entry_d = '0;
                        cnt_d   = '0;
                    end
                    KEY_ENT: begin
                        if (state_q == ST_EDIT && cnt_q != '0) begin
                            enter_ok  = 1'b1;
                            out_bcd_d = entry_q;
                            entry_d   = '0;
                            cnt_d     = '0;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                    default: key_err_d = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EDIT: begin
                if (enter_ok) begin
`ifdef KEY_ENTRY_BIN_EN
                    state_d = ST_CONV;
`else
                    state_d = ST_HOLD;
`endif
                end
            end
`ifdef KEY_ENTRY_BIN_EN
            ST_CONV: if (!conv_busy) state_d = ST_HOLD;
`endif
            ST_HOLD: if (bus.out_ready) state_d = ST_EDIT;
            default: state_d = ST_EDIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EDIT;
            key_valid_q <= 1'b0;
            armed_q     <= 1'b0;
            entry_q     <= '0;
            cnt_q       <= '0;
            out_bcd_q   <= '0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= bus.key_valid;
            armed_q     <= armed_q | ~bus.key_valid;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            out_bcd_q   <= out_bcd_d;
            key_err_q   <= key_err_d;
        end
    end

`ifdef KEY_ENTRY_BIN_EN
    bcd_to_bin_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_bcd_to_bin (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (enter_ok),
        .bcd_i   (entry_q),
        .busy_o  (conv_busy),
        .bin_o   (bus.out_bin)
    );
`endif

    assign bus.entry_bcd = entry_q;
    assign bus.entry_cnt = cnt_q;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.key_err   = key_err_q;

endmodule

`default_nettype wire
